// File: rtl/riscv_core_div_controller.sv
// Sequencer around an unsigned non-restoring divider core for DIV/DIVU/REM/REMU (+W forms).
// Optional result reuse ("fuse") of the last core operation is enabled by RISCV_DIV_CTRL_FUSE_EN.
module riscv_core_div_controller #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic            i_div_ctrl_clk,
  input  logic            i_div_ctrl_rst,
  input  logic            i_div_ctrl_valid,
  output logic            o_div_ctrl_ready,
  input  logic [1:0]      i_div_ctrl_op,
  input  logic            i_div_ctrl_word,
  input  logic [XLEN-1:0] i_div_ctrl_rs1,
  input  logic [XLEN-1:0] i_div_ctrl_rs2,
  input  logic [TAGW-1:0] i_div_ctrl_tag,
  input  logic            i_div_ctrl_flush,
  output logic            o_div_ctrl_resp_valid,
  input  logic            i_div_ctrl_resp_ready,
  output logic [XLEN-1:0] o_div_ctrl_result,
  output logic [TAGW-1:0] o_div_ctrl_tag,
  output logic            o_div_ctrl_busy,
  output logic            o_div_ctrl_core_en,
  output logic [XLEN-1:0] o_div_ctrl_core_dividend,
  output logic [XLEN-1:0] o_div_ctrl_core_divisor,
  input  logic            i_div_ctrl_core_done,
  input  logic [XLEN-1:0] i_div_ctrl_core_quotient,
  input  logic [XLEN-1:0] i_div_ctrl_core_remainder
);

  // Handshakes: a request transfers on a clock edge where valid && ready are both high;
  // a result transfers on an edge where resp_valid && resp_ready are both high. Flush wins.
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_FIX, S_RESP, S_DRAIN} state_t;

  state_t state, state_nxt;

  logic [1:0]      op_q;
  logic            word_q;
  logic [TAGW-1:0] tag_q;
  logic [XLEN-1:0] dvd_q, dvs_q, res_q;
  logic            neg_q, neg_r;

  logic            is_signed, is_rem, sa, sb, div0, ovf, fire, fuse_hit;
  logic [XLEN-1:0] a, b, mag_a, mag_b, min_val, spec_res, fix_val, fuse_val;

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{(XLEN-32){v[31]}}, v[31:0]};
  endfunction

  assign is_signed = ~i_div_ctrl_op[0];
  assign is_rem    = i_div_ctrl_op[1];
  assign fire      = i_div_ctrl_valid && (state == S_IDLE) && !i_div_ctrl_flush;

  always_comb begin
    a = i_div_ctrl_rs1;
    b = i_div_ctrl_rs2;
    if (i_div_ctrl_word) begin
      a = is_signed ? sext32(i_div_ctrl_rs1) : {{(XLEN-32){1'b0}}, i_div_ctrl_rs1[31:0]};
      b = is_signed ? sext32(i_div_ctrl_rs2) : {{(XLEN-32){1'b0}}, i_div_ctrl_rs2[31:0]};
    end
    sa      = is_signed & a[XLEN-1];
    sb      = is_signed & b[XLEN-1];
    mag_a   = sa ? ('0 - a) : a;
    mag_b   = sb ? ('0 - b) : b;
    min_val = i_div_ctrl_word ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div0    = (b == '0);
    ovf     = is_signed && (a == min_val) && (b == '1);
    spec_res = '0;
    if (div0)     spec_res = is_rem ? a : '1;
    else if (ovf) spec_res = is_rem ? '0 : a;
    // W results are always the sign-extended 32-bit value, including the shortcut paths.
    if (i_div_ctrl_word) spec_res = sext32(spec_res);
  end

  always_comb begin
    fix_val = (op_q[1] ? neg_r : neg_q) ? ('0 - res_q) : res_q;
    if (word_q) fix_val = sext32(fix_val);
  end

`ifdef RISCV_DIV_CTRL_FUSE_EN
  // Record of the last completed core run, keyed by magnitudes plus sign flags.
  logic            fuse_valid, fuse_nq, fuse_nr, fuse_signed, fuse_word;
  logic [XLEN-1:0] fuse_dvd, fuse_dvs, fuse_quo, fuse_rem;

  assign fuse_hit = fuse_valid && (fuse_dvd == mag_a) && (fuse_dvs == mag_b) &&
                    (fuse_nq == (sa ^ sb)) && (fuse_nr == sa) &&
                    (fuse_signed == is_signed) && (fuse_word == i_div_ctrl_word);
  assign fuse_val = is_rem ? fuse_rem : fuse_quo;

  always_ff @(posedge i_div_ctrl_clk) begin
    if (i_div_ctrl_rst || i_div_ctrl_flush) begin
      fuse_valid  <= 1'b0;
      fuse_nq     <= 1'b0;
      fuse_nr     <= 1'b0;
      fuse_signed <= 1'b0;
      fuse_word   <= 1'b0;
      fuse_dvd    <= '0;
      fuse_dvs    <= '0;
      fuse_quo    <= '0;
      fuse_rem    <= '0;
    end else if (state == S_WAIT && i_div_ctrl_core_done) begin
      fuse_valid  <= 1'b1;
      fuse_nq     <= neg_q;
      fuse_nr     <= neg_r;
      fuse_signed <= ~op_q[0];
      fuse_word   <= word_q;
      fuse_dvd    <= dvd_q;
      fuse_dvs    <= dvs_q;
      fuse_quo    <= i_div_ctrl_core_quotient;
      fuse_rem    <= i_div_ctrl_core_remainder;
    end
  end
`else
  assign fuse_hit = 1'b0;
  assign fuse_val = '0;
`endif

  always_ff @(posedge i_div_ctrl_clk) begin
    if (i_div_ctrl_rst) state <= S_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (fire) state_nxt = (div0 || ovf) ? S_RESP : (fuse_hit ? S_FIX : S_START);
      S_START: state_nxt = i_div_ctrl_flush ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (i_div_ctrl_flush)          state_nxt = i_div_ctrl_core_done ? S_IDLE : S_DRAIN;
        else if (i_div_ctrl_core_done) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = i_div_ctrl_flush ? S_IDLE : S_RESP;
      S_RESP:  if (i_div_ctrl_flush || i_div_ctrl_resp_ready) state_nxt = S_IDLE;
      S_DRAIN: if (i_div_ctrl_core_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_div_ctrl_clk) begin
    if (i_div_ctrl_rst) begin
      op_q   <= '0;
      word_q <= 1'b0;
      tag_q  <= '0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      res_q  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      if (fire) begin
        op_q   <= i_div_ctrl_op;
        word_q <= i_div_ctrl_word;
        tag_q  <= i_div_ctrl_tag;
        dvd_q  <= mag_a;
        dvs_q  <= mag_b;
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        res_q  <= (div0 || ovf) ? spec_res : fuse_val;
      end
      if (state == S_WAIT && i_div_ctrl_core_done && !i_div_ctrl_flush)
        res_q <= op_q[1] ? i_div_ctrl_core_remainder : i_div_ctrl_core_quotient;
      if (state == S_FIX) res_q <= fix_val;
    end
  end

  assign o_div_ctrl_ready         = (state == S_IDLE) && !i_div_ctrl_flush;
  assign o_div_ctrl_resp_valid    = (state == S_RESP) && !i_div_ctrl_flush;
  assign o_div_ctrl_result        = res_q;
  assign o_div_ctrl_tag           = tag_q;
  assign o_div_ctrl_busy          = (state != S_IDLE);
  assign o_div_ctrl_core_en       = (state == S_START);
  assign o_div_ctrl_core_dividend = dvd_q;
  assign o_div_ctrl_core_divisor  = dvs_q;

endmodule

// File: tb/tb_riscv_core_div_controller.sv
// Scoreboard bench for riscv_core_div_controller with a behavioural divider-core model.
// Latency expectations follow RISCV_DIV_CTRL_FUSE_EN when that macro is defined.
module tb_riscv_core_div_controller;
  localparam int XLEN = 64;
  localparam int TAGW = 5;

  logic            clk, rst, valid, ready, word, flush, resp_valid, resp_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1, rs2, result, core_dividend, core_divisor, core_q, core_r;
  logic [TAGW-1:0] tag, rtag;
  logic            busy, core_en, core_done;

  riscv_core_div_controller #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .i_div_ctrl_clk(clk), .i_div_ctrl_rst(rst),
    .i_div_ctrl_valid(valid), .o_div_ctrl_ready(ready),
    .i_div_ctrl_op(op), .i_div_ctrl_word(word),
    .i_div_ctrl_rs1(rs1), .i_div_ctrl_rs2(rs2), .i_div_ctrl_tag(tag),
    .i_div_ctrl_flush(flush),
    .o_div_ctrl_resp_valid(resp_valid), .i_div_ctrl_resp_ready(resp_ready),
    .o_div_ctrl_result(result), .o_div_ctrl_tag(rtag), .o_div_ctrl_busy(busy),
    .o_div_ctrl_core_en(core_en), .o_div_ctrl_core_dividend(core_dividend),
    .o_div_ctrl_core_divisor(core_divisor), .i_div_ctrl_core_done(core_done),
    .i_div_ctrl_core_quotient(core_q), .i_div_ctrl_core_remainder(core_r)
  );

  int checks = 0, failures = 0, cyc = 0, en_count = 0, ready_mode = 1, en_base = 0;
  bit discard_ok = 0, head_seen = 0, key_valid = 0;
  logic [XLEN+TAGW-1:0] exp_q[$];
  int acc_q[$], lat_q[$];
  logic [2*XLEN+1:0] key;
  logic [XLEN-1:0] prev_x = 64'd100, prev_y = 64'd7;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic w,
                                             input logic [63:0] x, input logic [63:0] y);
    logic sgn, rm;
    logic [31:0] a32, b32, r32;
    logic [63:0] r64;
    sgn = !o[0];
    rm  = o[1];
    a32 = x[31:0];
    b32 = y[31:0];
    if (w) begin
      if (b32 == 0) r32 = rm ? a32 : 32'hFFFFFFFF;
      else if (sgn && a32 == 32'h80000000 && b32 == 32'hFFFFFFFF) r32 = rm ? 32'h0 : a32;
      else if (sgn) r32 = rm ? 32'($signed(a32) % $signed(b32)) : 32'($signed(a32) / $signed(b32));
      else r32 = rm ? a32 % b32 : a32 / b32;
      return {{32{r32[31]}}, r32};
    end
    if (y == 0) r64 = rm ? x : 64'hFFFFFFFFFFFFFFFF;
    else if (sgn && x == 64'h8000000000000000 && y == 64'hFFFFFFFFFFFFFFFF) r64 = rm ? 64'h0 : x;
    else if (sgn) r64 = rm ? 64'($signed(x) % $signed(y)) : 64'($signed(x) / $signed(y));
    else r64 = rm ? x % y : x / y;
    return r64;
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic w,
                                    input logic [63:0] x, input logic [63:0] y);
    if (w) return (y[31:0] == 0) || (!o[0] && x[31:0] == 32'h80000000 && y[31:0] == 32'hFFFFFFFF);
    return (y == 0) || (!o[0] && x == 64'h8000000000000000 && y == 64'hFFFFFFFFFFFFFFFF);
  endfunction

  function automatic logic [63:0] prep(input logic [1:0] o, input logic w, input logic [63:0] x);
    if (!w) return x;
    return o[0] ? {32'h0, x[31:0]} : {{32{x[31]}}, x[31:0]};
  endfunction

  // ---------------- divider core model ----------------
  initial begin
    logic [63:0] d, s;
    core_done = 0;
    core_q = 0;
    core_r = 0;
    forever begin
      @(negedge clk);
      if (core_en) begin
        en_count++;
        d = core_dividend;
        s = core_divisor;
        repeat (65) @(posedge clk);
        #1;
        core_done = 1;
        core_q = (s == 0) ? 64'hFFFFFFFFFFFFFFFF : d / s;
        core_r = (s == 0) ? d : d % s;
        @(posedge clk);
        #1;
        core_done = 0;
        core_q = 0;
        core_r = 0;
      end
    end
  end

  // ---------------- response ready driver ----------------
  initial begin
    resp_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       resp_ready = 1'($urandom_range(0, 1));
        1:       resp_ready = 1'b1;
        default: resp_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial forever begin
    @(negedge clk);
    if (resp_valid && !discard_ok) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%h required=none", result);
      end else begin
        if (!head_seen) begin
          head_seen = 1;
          check("latency", 64'(cyc - acc_q[0] + 1), 64'(lat_q[0]));
        end
        check("ready_in_resp", {63'b0, ready}, 64'd0);
        check("result", result, exp_q[0][XLEN+TAGW-1:TAGW]);
        check("tag", {59'b0, rtag}, {59'b0, exp_q[0][TAGW-1:0]});
        if (resp_ready) begin
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          void'(lat_q.pop_front());
          head_seen = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic w, input logic [63:0] x,
                       input logic [63:0] y, input bit push);
    bit sp, hit, got;
    logic [2*XLEN+1:0] k;
    logic [TAGW-1:0] t;
    int lat;
    sp  = is_special(o, w, x, y);
    k   = {w, !o[0], prep(o, w, x), prep(o, w, y)};
    hit = 0;
`ifdef RISCV_DIV_CTRL_FUSE_EN
    hit = !sp && key_valid && (key == k);
`endif
    lat = sp ? 1 : (hit ? 2 : XLEN + 4);
    t = TAGW'($urandom_range(0, 31));
    en_base = en_count;
    @(posedge clk);
    #1;
    valid = 1; op = o; word = w; rs1 = x; rs2 = y; tag = t;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1;
        if (push) begin
          exp_q.push_back({ref_result(o, w, x, y), t});
          acc_q.push_back(cyc + 1);
          lat_q.push_back(lat);
        end
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=not_ready required=ready");
    end
    @(posedge clk);
    #1;
    valid = 0;
    if (got && !sp && !hit) begin
      key_valid = 1;
      key = k;
    end
  endtask

  task automatic wait_drain(input int en_exp);
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
      exp_q.delete(); acc_q.delete(); lat_q.delete();
      head_seen = 0;
    end
    check("core_en_count", 64'(en_count - en_base), 64'(en_exp));
  endtask

  task automatic run_op(input logic [1:0] o, input logic w, input logic [63:0] x, input logic [63:0] y);
    bit runs_core;
    runs_core = !is_special(o, w, x, y);
`ifdef RISCV_DIV_CTRL_FUSE_EN
    if (key_valid && key == {w, !o[0], prep(o, w, x), prep(o, w, y)}) runs_core = 0;
`endif
    issue(o, w, x, y, 1);
    wait_drain(runs_core ? 1 : 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok, seen;
    logic [1:0] ro;
    logic rw;
    logic [63:0] rx, ry;
    int cat;
    rst = 1; valid = 0; op = 0; word = 0; rs1 = 0; rs2 = 0; tag = 0; flush = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_ready", {63'b0, ready}, 64'd1);
    check("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_core_en", {63'b0, core_en}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_tag", {59'b0, rtag}, 64'd0);
    check("rst_core_operands", core_dividend | core_divisor, 64'd0);

    ready_mode = 1;
    run_op(2'b00, 0, 64'hFFFFFFFFFFFFFFF9, 64'd2);
    run_op(2'b10, 0, 64'hFFFFFFFFFFFFFFF9, 64'd2);
    run_op(2'b01, 0, 64'd5, 64'd0);
    run_op(2'b11, 0, 64'd5, 64'd0);
    run_op(2'b00, 0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF);
    run_op(2'b10, 0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF);
    run_op(2'b00, 1, 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFF);
    run_op(2'b01, 1, 64'hFFFFFFFFFFFFFFFE, 64'd2);
    run_op(2'b00, 1, 64'h00000000FFFFFFF9, 64'd2);
    run_op(2'b00, 0, 64'd100, 64'd7);
    run_op(2'b10, 0, 64'd100, 64'd7);

    // Response held off for 10 cycles: result/tag must stay put and ready stays low.
    ready_mode = 2;
    issue(2'b01, 0, 64'd9, 64'd0, 1);
    repeat (10) @(posedge clk);
    ready_mode = 1;
    wait_drain(0);

    // Flush while waiting on the core.
    issue(2'b01, 0, 64'd1000, 64'd3, 0);
    repeat (20) @(posedge clk);
    #1 flush = 1;
    @(posedge clk);
    #1 flush = 0;
    key_valid = 0;
    ok = 1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (core_done) begin
        seen = 1;
        break;
      end
      if (!busy || ready) ok = 0;
    end
    check("drain_busy", {63'b0, ok}, 64'd1);
    check("drain_done_seen", {63'b0, seen}, 64'd1);
    @(negedge clk);
    check("drain_ready_after", {63'b0, ready}, 64'd1);
    check("drain_busy_after", {63'b0, busy}, 64'd0);

    // Flush while holding a response.
    ready_mode = 2;
    discard_ok = 1;
    issue(2'b00, 0, 64'd3, 64'd0, 0);
    @(negedge clk);
    check("resp_before_flush", {63'b0, resp_valid}, 64'd1);
    @(posedge clk);
    #1 flush = 1;
    @(negedge clk);
    check("resp_during_flush", {63'b0, resp_valid}, 64'd0);
    @(posedge clk);
    #1 flush = 0;
    @(negedge clk);
    check("ready_after_resp_flush", {63'b0, ready}, 64'd1);
    check("busy_after_resp_flush", {63'b0, busy}, 64'd0);
    discard_ok = 0;
    key_valid = 0;

    // Flush in IDLE blocks a same-cycle request.
    @(posedge clk);
    #1 flush = 1; valid = 1; op = 2'b01; rs1 = 64'd8; rs2 = 64'd0;
    @(negedge clk);
    check("idle_flush_ready", {63'b0, ready}, 64'd0);
    @(posedge clk);
    #1 flush = 0; valid = 0;
    @(negedge clk);
    check("idle_flush_busy", {63'b0, busy}, 64'd0);

    ready_mode = 0;
    for (int n = 0; n < 40; n++) begin
      ro  = 2'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));
      cat = $urandom_range(0, 15);
      rx  = {$urandom, $urandom};
      ry  = {$urandom, $urandom};
      if (cat < 4) begin
        ry = 64'($urandom_range(1, 1000));
        if ($urandom_range(0, 1) == 1) ry = 64'd0 - ry;
      end else if (cat == 4) ry = 64'd0;
      else if (cat == 5) begin
        rx = rw ? 64'h0000000080000000 : 64'h8000000000000000;
        ry = 64'hFFFFFFFFFFFFFFFF;
      end else if (cat < 10) begin
        rx = prev_x;
        ry = prev_y;
      end else if (cat < 12) begin
        rx = 64'($urandom_range(0, 5000));
        ry = 64'($urandom_range(1, 50));
      end
      prev_x = rx;
      prev_y = ry;
      run_op(ro, rw, rx, ry);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_core_div_controller.md
Name: riscv_core_div_controller

Overview:
Sequencer for the unsigned non-restoring divider core in the M-extension path. Accepts DIV/DIVU/REM/REMU and the RV64 W variants from the execute stage. Converts signed operands to magnitudes, short-circuits divide-by-zero and signed overflow, and starts the core. Captures the core's one-cycle done pulse, applies sign correction and W sign-extension, then holds the result under a valid/ready handshake.

Parameters:
XLEN, 64, datapath width; must match the core.
TAGW, 5, width of the opaque request tag (rd index).

Ports:
i_div_ctrl_clk  in  1  clock; also clocks the core
i_div_ctrl_rst  in  1  synchronous active-high reset
i_div_ctrl_valid  in  1  request valid
o_div_ctrl_ready  out  1  request accepted when valid&&ready
i_div_ctrl_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
i_div_ctrl_word  in  1  1 = W variant (32-bit operation)
i_div_ctrl_rs1  in  XLEN  dividend
i_div_ctrl_rs2  in  XLEN  divisor
i_div_ctrl_tag  in  TAGW  tag returned with the result
i_div_ctrl_flush  in  1  abort the in-flight or held request
o_div_ctrl_resp_valid  out  1  result valid
i_div_ctrl_resp_ready  in  1  result consumed when valid&&ready
o_div_ctrl_result  out  XLEN  final rd value
o_div_ctrl_tag  out  TAGW  tag of the result
o_div_ctrl_busy  out  1  state != IDLE
o_div_ctrl_core_en  out  1  core start pulse
o_div_ctrl_core_dividend  out  XLEN  magnitude dividend to the core
o_div_ctrl_core_divisor  out  XLEN  magnitude divisor to the core
i_div_ctrl_core_done  in  1  core one-cycle done pulse
i_div_ctrl_core_quotient  in  XLEN  core quotient, valid only while done is high
i_div_ctrl_core_remainder  in  XLEN  core remainder, valid only while done is high

Behaviour:
- Reset: state IDLE; all outputs 0 except o_div_ctrl_ready=1. Operand, tag and result registers are cleared. The core is reset from the same source in the top level.
- States: IDLE, START, WAIT, FIX, RESP, DRAIN.
- o_div_ctrl_ready=1 only in IDLE.
- Accept, IDLE -> START or RESP: registers the op, word flag and tag.
  - Operand preparation: if word, rs1 and rs2 are reduced to their low 32 bits, sign-extended for DIV/REM and zero-extended for DIVU/REMU.
  - Signed ops register magnitude(x), neg_q = sign(a) XOR sign(b), and neg_r = sign(a).
  - Special cases go straight to RESP.
    - Divisor == 0: result is all-ones for DIV/DIVU and the prepared dividend for REM/REMU.
    - Signed overflow (dividend = most-negative value of the operating width, divisor = -1): DIV returns the dividend, REM returns 0.
  - Otherwise -> START.
- START: o_div_ctrl_core_en=1 for exactly one cycle, with the core operand ports driven from registers, then -> WAIT. core_en is 0 in every other state.
- WAIT: on i_div_ctrl_core_done, capture the quotient or remainder, then -> FIX.
- FIX:
  - Negate (two's complement) the quotient if neg_q, or the remainder if neg_r.
  - If word, sign-extend bit 31 into the upper bits; this applies to all W ops, including DIVUW/REMUW.
  - Then -> RESP.
- RESP: o_div_ctrl_resp_valid=1; result and tag are held stable until resp_ready, then -> IDLE.
- Latency from the accept edge (XLEN=64): START is cycle 1, core done arrives at cycle 66, FIX is cycle 67, resp_valid rises at cycle 68 (XLEN+4). Special cases raise resp_valid at cycle 1.
- Flush:
  - In START or WAIT: -> DRAIN, which waits for core_done, discards the result, then -> IDLE.
  - In RESP: drop resp_valid and -> IDLE the next cycle.
  - In IDLE: has no effect, and a request in the same cycle is not accepted.
  - If flush and core_done coincide in WAIT: the result is discarded and the block -> IDLE directly.
- resp_valid and resp_ready in the same cycle: exactly one transfer; the new request is accepted the next cycle (no back-to-back bypass).
- Synchronous reset mid-operation returns to IDLE regardless of the core's state.

Optional Feature:
Macro RISCV_DIV_CTRL_FUSE_EN.
- When defined:
  - A fuse record holds both quotient and remainder of the last completed core operation, together with its prepared operands, signedness and word flag.
  - A new request with identical operands, signedness and word flag goes IDLE -> FIX using the stored values, skipping the core. Response comes at cycle 2.
  - The record is invalidated by reset and by flush.
- When undefined: every non-special request runs the core, and no fuse storage is generated.

Test Plan:
- DIV rs1=-7, rs2=2 -> result 0xFFFFFFFFFFFFFFFD at cycle 68; REM with the same operands -> 0xFFFFFFFFFFFFFFFF.
- DIVU rs1=5, rs2=0 -> 0xFFFFFFFFFFFFFFFF at cycle 1; REMU rs1=5, rs2=0 -> 5; core_en never asserted.
- DIV rs1=0x8000000000000000, rs2=-1 -> 0x8000000000000000; REM -> 0; DIVW rs1=0x80000000, rs2=-1 -> 0xFFFFFFFF80000000.
- DIVUW rs1=0xFFFFFFFFFFFFFFFE, rs2=2 -> 0x000000007FFFFFFF; DIVW rs1=0x00000000FFFFFFF9, rs2=2 -> 0xFFFFFFFFFFFFFFFD.
- resp_ready held low for 10 cycles -> result and tag stable and ready=0; flush at cycle 20 of WAIT -> no response, busy held until core done, then ready=1.
- With RISCV_DIV_CTRL_FUSE_EN: DIV 100/7 -> 14; then REM 100/7 -> 2 at cycle 2 with no core_en; without the macro -> 2 at cycle 68.
